conv_window_sched: RTL

- Controller that sequences one K x K valid convolution (stride 1) over an IMG_W x IMG_H single-channel image buffer.
- Generates image-buffer and weight-ROM read addresses, MAC enable and accumulator-clear strobes, and output-buffer write strobes.
- Sits between the top-level control and the MAC/accumulator datapath.
- Started by a one-cycle en pulse; reports completion with a one-cycle done pulse.

---
 rtl/conv_window_sched.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/conv_window_sched.sv
// rtl/conv_window_sched.sv - K x K valid-convolution address/strobe sequencer
// Optional bias tap per window enabled by defining CONV_BIAS_EN.
module conv_window_sched #(
   parameter int IMG_W      = 8,
   parameter int IMG_H      = 8,
   parameter int K          = 3,
   parameter int ADDR_W     = 6,
   parameter int W_ADDR_W   = 4,
   parameter int OUT_ADDR_W = 6,
   parameter int RD_LAT     = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   output logic [ADDR_W-1:0]     img_addr,
   output logic                  img_rd,
   output logic [W_ADDR_W-1:0]   w_addr,
   output logic                  mac_en,
   output logic                  acc_clr,
   output logic [OUT_ADDR_W-1:0] out_addr,
   output logic                  out_we,
   output logic                  busy,
   output logic                  done
`ifdef CONV_BIAS_EN
   ,
   output logic                  bias_rd
`endif
);

   localparam int OUT_W = IMG_W - K + 1;
   localparam int OUT_H = IMG_H - K + 1;

   typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_WRITE, S_DONE} state_t;

   state_t              r_state, w_next;
   logic [15:0]         r_row, r_col, r_ki, r_kj, r_dcnt;
   logic [RD_LAT-1:0]   r_rd_pipe, r_clr_pipe;
   logic                w_last_tap, w_last_win, w_drain_end;
   logic                w_bias_tap, w_img_tap, w_tap0;

   assign w_last_tap  = (r_ki == 16'(K - 1)) && (r_kj == 16'(K - 1));
   assign w_last_win  = (r_row == 16'(OUT_H - 1)) && (r_col == 16'(OUT_W - 1));
   assign w_drain_end = (r_dcnt == 16'(RD_LAT - 1));

`ifdef CONV_BIAS_EN
   logic r_bias_ph;
   assign w_bias_tap = (r_state == S_RUN) && r_bias_ph;
   assign bias_rd    = w_bias_tap;
`else
   assign w_bias_tap = 1'b0;
`endif

   assign w_img_tap = (r_state == S_RUN) && !w_bias_tap;
   assign w_tap0    = w_img_tap && (r_ki == 16'd0) && (r_kj == 16'd0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (en) w_next = S_RUN;
`ifdef CONV_BIAS_EN
         S_RUN:   if (r_bias_ph) w_next = S_DRAIN;
`else
         S_RUN:   if (w_last_tap) w_next = S_DRAIN;
`endif
         S_DRAIN: if (w_drain_end) w_next = S_WRITE;
         S_WRITE: w_next = w_last_win ? S_DONE : S_RUN;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_row  <= '0;
         r_col  <= '0;
         r_ki   <= '0;
         r_kj   <= '0;
         r_dcnt <= '0;
`ifdef CONV_BIAS_EN
         r_bias_ph <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               r_row  <= '0;
               r_col  <= '0;
               r_ki   <= '0;
               r_kj   <= '0;
               r_dcnt <= '0;
            end
            S_RUN: begin
`ifdef CONV_BIAS_EN
               if (r_bias_ph) r_bias_ph <= 1'b0;
               else
`endif
               if (w_last_tap) begin
                  r_ki <= '0;
                  r_kj <= '0;
`ifdef CONV_BIAS_EN
                  r_bias_ph <= 1'b1;
`endif
               end else if (r_kj == 16'(K - 1)) begin
                  r_kj <= '0;
                  r_ki <= r_ki + 16'd1;
               end else begin
                  r_kj <= r_kj + 16'd1;
               end
            end
            S_DRAIN: r_dcnt <= w_drain_end ? 16'd0 : r_dcnt + 16'd1;
            S_WRITE: begin
               if (w_last_win) begin
                  r_row <= '0;
                  r_col <= '0;
               end else if (r_col == 16'(OUT_W - 1)) begin
                  r_col <= '0;
                  r_row <= r_row + 16'd1;
               end else begin
                  r_col <= r_col + 16'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // Both pipes model the memory read latency so mac_en/acc_clr align with returned data.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rd_pipe  <= '0;
         r_clr_pipe <= '0;
      end else begin
         for (int i = RD_LAT - 1; i > 0; i--) begin
            r_rd_pipe[i]  <= r_rd_pipe[i-1];
            r_clr_pipe[i] <= r_clr_pipe[i-1];
         end
         r_rd_pipe[0]  <= (r_state == S_RUN);
         r_clr_pipe[0] <= w_tap0;
      end
   end

   assign img_rd   = w_img_tap;
   assign img_addr = w_img_tap ?
                     ADDR_W'((32'(r_row) + 32'(r_ki)) * 32'(IMG_W) + 32'(r_col) + 32'(r_kj)) : '0;
   assign w_addr   = w_bias_tap ? W_ADDR_W'(K * K) :
                     w_img_tap  ? W_ADDR_W'(32'(r_ki) * 32'(K) + 32'(r_kj)) : '0;
   assign mac_en   = r_rd_pipe[RD_LAT-1];
   assign acc_clr  = r_clr_pipe[RD_LAT-1];
   assign out_we   = (r_state == S_WRITE);
   assign out_addr = (r_state == S_WRITE) ?
                     OUT_ADDR_W'(32'(r_row) * 32'(OUT_W) + 32'(r_col)) : '0;
   assign busy     = (r_state == S_RUN) || (r_state == S_DRAIN) || (r_state == S_WRITE);
   assign done     = (r_state == S_DONE);

endmodule
